// File: rtl/updown_counter_param.sv
// rtl/updown_counter_param.sv - parametrised up/down counter with prescaler, wrap/saturate, tc pulse and sticky flags
module updown_counter_param #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic [WIDTH-1:0]      limit,
    input  logic                  sat_mode,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  clr_sticky,
    output logic [WIDTH-1:0]      count,
    output logic                  tc,
    output logic                  at_max,
    output logic                  at_zero,
    output logic                  ovf_sticky,
    output logic                  unf_sticky
);

    logic [PRESCALE_W-1:0] pdiv;
    logic                  step;
    logic                  up_bound;
    logic                  dn_bound;
    logic                  ovf_set;
    logic                  unf_set;
    logic [WIDTH-1:0]      count_next;

    assign at_max  = (count == limit);
    assign at_zero = (count == '0);

    // load has priority, so a step is only possible on non-load edges
    assign step     = en && !load && (pdiv == prescale);
    assign up_bound = (count >= limit);
    assign dn_bound = (count == '0);
    assign ovf_set  = step && up && up_bound;
    assign unf_set  = step && !up && dn_bound;

    always_comb begin
        count_next = count;
        if (up) begin
            if (!up_bound)     count_next = count + 1'b1;
            else if (sat_mode) count_next = limit;
            else               count_next = '0;
        end else begin
            if (!dn_bound)     count_next = count - 1'b1;
            else if (sat_mode) count_next = '0;
            else               count_next = limit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            pdiv  <= '0;
            tc    <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (load) begin
                count <= load_val;
                pdiv  <= '0;
            end else if (en) begin
                if (pdiv == prescale) begin
                    pdiv  <= '0;
                    count <= count_next;
                    tc    <= ovf_set || unf_set;
                end else begin
                    pdiv <= pdiv + 1'b1;
                end
            end
        end
    end

    // a set event in the same cycle overrides the clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
            unf_sticky <= 1'b0;
        end else begin
            ovf_sticky <= ovf_set || (ovf_sticky && !clr_sticky);
            unf_sticky <= unf_set || (unf_sticky && !clr_sticky);
        end
    end

endmodule

// File: tb/tb_updown_counter_param.sv
// tb/tb_updown_counter_param.sv - self-checking bench for updown_counter_param
module tb_updown_counter_param;
    localparam int W = 8;
    localparam int P = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en, up, load, sat_mode, clr_sticky;
    logic [W-1:0] load_val, limit;
    logic [P-1:0] prescale;
    logic [W-1:0] count;
    logic         tc, at_max, at_zero, ovf_sticky, unf_sticky;

    int errors = 0;
    int checks = 0;

    int m_count, m_pdiv;
    bit m_tc, m_ovf, m_unf;

    updown_counter_param #(.WIDTH(W), .PRESCALE_W(P)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
        .load_val(load_val), .limit(limit), .sat_mode(sat_mode),
        .prescale(prescale), .clr_sticky(clr_sticky), .count(count),
        .tc(tc), .at_max(at_max), .at_zero(at_zero),
        .ovf_sticky(ovf_sticky), .unf_sticky(unf_sticky)
    );

    always #5 clk = ~clk;

    // reference: next state computed from the rules, then one clock edge
    task automatic tick();
        int  c, p, lim;
        bit  t, os, us;
        c = m_count; p = m_pdiv; lim = int'(limit); t = 0;
        os = m_ovf && !clr_sticky;
        us = m_unf && !clr_sticky;
        if (load) begin
            c = int'(load_val); p = 0;
        end else if (en) begin
            if (p == int'(prescale)) begin
                p = 0;
                if (up) begin
                    if (c < lim) c = c + 1;
                    else begin c = sat_mode ? lim : 0; t = 1; os = 1; end
                end else begin
                    if (c > 0) c = c - 1;
                    else begin c = sat_mode ? 0 : lim; t = 1; us = 1; end
                end
            end else begin
                p = (p + 1) % (1 << P);
            end
        end
        @(posedge clk);
        #1;
        m_count = c; m_pdiv = p; m_tc = t; m_ovf = os; m_unf = us;
    endtask

    task automatic do_reset();
        en = 0; up = 1; load = 0; sat_mode = 0; clr_sticky = 0;
        load_val = '0; limit = 8'd9; prescale = '0;
        @(negedge clk);
        rst_n = 0;
        m_count = 0; m_pdiv = 0; m_tc = 0; m_ovf = 0; m_unf = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (count !== 8'd0 || tc !== 1'b0 || ovf_sticky !== 1'b0 || unf_sticky !== 1'b0 || at_zero !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: count=%0h tc=%b ovf=%b unf=%b at_zero=%b, required 0 0 0 0 1",
                     count, tc, ovf_sticky, unf_sticky, at_zero);
        end
        limit = 8'h20; load = 1; load_val = 8'h37; tick();
        load = 0; en = 1; up = 1; tick();
        load = 1; en = 0; tick();
        load = 0;
        checks++;
        if (count !== 8'h37 || ovf_sticky !== 1'b1) begin
            errors++;
            $display("FAIL reset_precond: count=%0h ovf=%b, required 37 1", count, ovf_sticky);
        end
        #2 rst_n = 0;
        #1;
        checks++;
        if (count !== 8'd0 || tc !== 1'b0 || ovf_sticky !== 1'b0 || unf_sticky !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: count=%0h tc=%b ovf=%b unf=%b, required all 0",
                     count, tc, ovf_sticky, unf_sticky);
        end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_wrap_up();
        int tcs = 0;
        do_reset();
        limit = 8'd9; sat_mode = 0; up = 1; en = 1; prescale = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (tc) tcs++;
            checks++;
            if (count !== W'(i < 9 ? i + 1 : i - 9) || tc !== (i == 9)) begin
                errors++;
                $display("FAIL wrap_up[%0d]: count=%0d tc=%b, required %0d %b",
                         i, count, tc, (i < 9 ? i + 1 : i - 9), (i == 9));
            end
        end
        checks++;
        if (tcs != 1 || ovf_sticky !== 1'b1) begin
            errors++;
            $display("FAIL wrap_up_flags: tc_pulses=%0d ovf=%b, required 1 1", tcs, ovf_sticky);
        end
    endtask

    task automatic test_sat_down();
        do_reset();
        load = 1; load_val = 8'd2; tick();
        load = 0; up = 0; sat_mode = 1; en = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (count !== W'(i < 2 ? 1 - i : 0) || tc !== (i >= 2)) begin
                errors++;
                $display("FAIL sat_down[%0d]: count=%0d tc=%b, required %0d %b",
                         i, count, tc, (i < 2 ? 1 - i : 0), (i >= 2));
            end
        end
        checks++;
        if (unf_sticky !== 1'b1 || at_zero !== 1'b1 || ovf_sticky !== 1'b0) begin
            errors++;
            $display("FAIL sat_down_flags: unf=%b at_zero=%b ovf=%b, required 1 1 0", unf_sticky, at_zero, ovf_sticky);
        end
    endtask

    task automatic test_prescaler();
        do_reset();
        limit = 8'hFF; prescale = 4'd3; up = 1; en = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (count !== W'((i + 1) / 4)) begin
                errors++;
                $display("FAIL prescale[%0d]: count=%0d, required %0d", i, count, (i + 1) / 4);
            end
        end
        en = 0;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (count !== 8'd3) begin
            errors++;
            $display("FAIL prescale_hold: count=%0d, required 3", count);
        end
        en = 1;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (count !== 8'd3) begin
            errors++;
            $display("FAIL prescale_pdiv_frozen: count=%0d, required 3", count);
        end
        tick();
        checks++;
        if (count !== 8'd4) begin
            errors++;
            $display("FAIL prescale_resume: count=%0d, required 4", count);
        end
    endtask

    task automatic test_load_priority();
        do_reset();
        limit = 8'h10; en = 1; prescale = 0; up = 1; sat_mode = 0;
        load = 1; load_val = 8'hF0; tick();
        checks++;
        if (count !== 8'hF0 || tc !== 1'b0) begin
            errors++;
            $display("FAIL load_oor: count=%0h tc=%b, required f0 0", count, tc);
        end
        load = 0; tick();
        checks++;
        if (count !== 8'h00 || tc !== 1'b1 || ovf_sticky !== 1'b1) begin
            errors++;
            $display("FAIL load_wrap: count=%0h tc=%b ovf=%b, required 0 1 1", count, tc, ovf_sticky);
        end
        load = 1; tick();
        load = 0; up = 0; tick();
        checks++;
        if (count !== 8'hEF || tc !== 1'b0) begin
            errors++;
            $display("FAIL load_down: count=%0h tc=%b, required ef 0", count, tc);
        end
        load = 1; load_val = 8'h10; en = 0; tick();
        load = 0;
        checks++;
        if (at_max !== 1'b1 || at_zero !== 1'b0) begin
            errors++;
            $display("FAIL at_max: at_max=%b at_zero=%b, required 1 0", at_max, at_zero);
        end
    endtask

    task automatic test_sticky_race();
        do_reset();
        limit = 8'd5; load = 1; load_val = 8'd5; tick();
        load = 0; up = 1; en = 1; clr_sticky = 1; tick();
        checks++;
        if (ovf_sticky !== 1'b1 || count !== 8'd0 || tc !== 1'b1) begin
            errors++;
            $display("FAIL sticky_race: ovf=%b count=%0d tc=%b, required 1 0 1", ovf_sticky, count, tc);
        end
        en = 0; tick();
        clr_sticky = 0;
        checks++;
        if (ovf_sticky !== 1'b0 || unf_sticky !== 1'b0) begin
            errors++;
            $display("FAIL sticky_clear: ovf=%b unf=%b, required 0 0", ovf_sticky, unf_sticky);
        end
    endtask

    task automatic test_random();
        do_reset();
        limit = W'($urandom_range(0, 20));
        for (int i = 0; i < 800; i++) begin
            en         = ($urandom % 4) != 0;
            up         = $urandom % 2;
            load       = ($urandom % 16) == 0;
            load_val   = W'($urandom);
            sat_mode   = $urandom % 2;
            clr_sticky = ($urandom % 8) == 0;
            if ($urandom % 32 == 0) limit = W'($urandom_range(0, 20));
            if ($urandom % 24 == 0) prescale = P'($urandom_range(0, 2));
            tick();
            checks++;
            if (count !== W'(m_count) || tc !== m_tc || ovf_sticky !== m_ovf || unf_sticky !== m_unf ||
                at_max !== (m_count == int'(limit)) || at_zero !== (m_count == 0)) begin
                errors++;
                $display("FAIL random[%0d]: count=%0d tc=%b ovf=%b unf=%b max=%b zero=%b, required %0d %b %b %b %b %b",
                         i, count, tc, ovf_sticky, unf_sticky, at_max, at_zero,
                         m_count, m_tc, m_ovf, m_unf, (m_count == int'(limit)), (m_count == 0));
            end
        end
    endtask

    initial begin
        rst_n = 0;
        test_reset();
        test_wrap_up();
        test_sat_down();
        test_prescaler();
        test_load_priority();
        test_sticky_race();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
